// File: rtl/alu_issue_scheduler.sv
// alu_issue_scheduler
// ---------------------------------------------------------------------------
// Shares a pool of NUM_ALU vector ALU controllers among one in-order issue
// stream. An offered instruction is accepted over valid/ready and dispatched
// to a free, ready ALU chosen round-robin. Each ALU is tracked as FREE, BUSY
// or DONE_PEND. Completions are serialised, lowest ALU index first, onto a
// single retire port toward the wavepool.
//
// Optional feature macro: ALU_WATCHDOG_EN
//   When defined, every ALU gets a watchdog counter. An ALU that stays BUSY
//   for WDOG_CYCLES cycles without a done pulse is forced to DONE_PEND and
//   retired with out_done_timeout=1, which also raises out_protocol_err.
//   When undefined, no counters exist and out_done_timeout is tied to 0.
//
// Ports:
//   clk              rising-edge clock
//   rst              asynchronous active-low reset
//   in_issue_valid   instruction offered
//   in_issue_wfid    wavefront id of offered instruction
//   in_issue_opcode  opcode forwarded to the ALU
//   out_issue_ready  scheduler can accept this cycle (from registered state)
//   out_alu_select   one-hot, single-cycle dispatch pulse per ALU
//   out_alu_opcode   opcode of the last dispatch, held until the next one
//   in_alu_ready     per-ALU ready from its controller FSM
//   in_instr_done    per-ALU completion pulse
//   out_done_valid   single-cycle retire strobe
//   out_done_wfid    wfid of the retiring instruction
//   out_done_alu_id  index of the retiring ALU
//   out_done_timeout retire caused by the watchdog
//   out_busy_count   number of ALUs not FREE
//   out_protocol_err sticky protocol error flag, cleared only by reset
// ---------------------------------------------------------------------------
module alu_issue_scheduler #(
   parameter int NUM_ALU      = 4,
   parameter int ALU_ID_WIDTH = 2,
   parameter int WFID_WIDTH   = 6,
   parameter int WDOG_CYCLES  = 1024
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_issue_valid,
   input  logic [WFID_WIDTH-1:0]   in_issue_wfid,
   input  logic [31:0]             in_issue_opcode,
   output logic                    out_issue_ready,
   output logic [NUM_ALU-1:0]      out_alu_select,
   output logic [31:0]             out_alu_opcode,
   input  logic [NUM_ALU-1:0]      in_alu_ready,
   input  logic [NUM_ALU-1:0]      in_instr_done,
   output logic                    out_done_valid,
   output logic [WFID_WIDTH-1:0]   out_done_wfid,
   output logic [ALU_ID_WIDTH-1:0] out_done_alu_id,
   output logic                    out_done_timeout,
   output logic [ALU_ID_WIDTH:0]   out_busy_count,
   output logic                    out_protocol_err
);

   typedef enum logic [1:0] {
      ST_FREE      = 2'd0,
      ST_BUSY      = 2'd1,
      ST_DONE_PEND = 2'd2
   } alu_state_e;

   // Round-robin pick: first set bit of elig at or after ptr, wrapping.
   // Result MSB is the found flag, low bits the index. Scanning downwards
   // lets the nearest candidate overwrite farther ones.
   function automatic logic [ALU_ID_WIDTH:0] pick_rr(
      input logic [NUM_ALU-1:0]      elig,
      input logic [ALU_ID_WIDTH-1:0] ptr
   );
      logic [ALU_ID_WIDTH:0] res;
      int                    idx;
      res = '0;
      for (int k = NUM_ALU - 1; k >= 0; k--) begin
         idx = int'(ptr) + k;
         if (idx >= NUM_ALU) begin
            idx = idx - NUM_ALU;
         end else begin
            idx = idx;
         end
         if (elig[idx]) begin
            res = {1'b1, ALU_ID_WIDTH'(idx)};
         end else begin
            res = res;
         end
      end
      return res;
   endfunction

   // Registered state
   alu_state_e              alu_state_q [NUM_ALU];
   alu_state_e              alu_state_d [NUM_ALU];
   logic [WFID_WIDTH-1:0]   wfid_q      [NUM_ALU];
   logic [WFID_WIDTH-1:0]   wfid_d      [NUM_ALU];
   logic [ALU_ID_WIDTH-1:0] rr_ptr_q,      rr_ptr_d;
   logic [NUM_ALU-1:0]      alu_select_q,  alu_select_d;
   logic [31:0]             alu_opcode_q,  alu_opcode_d;
   logic                    done_valid_q,  done_valid_d;
   logic [WFID_WIDTH-1:0]   done_wfid_q,   done_wfid_d;
   logic [ALU_ID_WIDTH-1:0] done_alu_id_q, done_alu_id_d;
   logic                    done_to_q,     done_to_d;
   logic [ALU_ID_WIDTH:0]   busy_count_q,  busy_count_d;
   logic                    proto_err_q,   proto_err_d;

   // Combinational decode of registered state
   logic [NUM_ALU-1:0]      elig_s;
   logic [NUM_ALU-1:0]      pend_s;
   logic [ALU_ID_WIDTH:0]   grant_s;
   logic                    accept_s;
   logic [ALU_ID_WIDTH-1:0] grant_idx_s;
   logic                    retire_found_s;
   logic [ALU_ID_WIDTH-1:0] retire_idx_s;

`ifdef ALU_WATCHDOG_EN
   localparam int CNT_W = $clog2(WDOG_CYCLES) + 1;
   logic [CNT_W-1:0] wdog_cnt_q [NUM_ALU];
   logic [CNT_W-1:0] wdog_cnt_d [NUM_ALU];
   logic [NUM_ALU-1:0] wdog_to_q, wdog_to_d;
`endif

   // Eligibility, grant selection and lowest-index retire selection.
   always_comb begin
      elig_s         = '0;
      pend_s         = '0;
      retire_found_s = 1'b0;
      retire_idx_s   = '0;
      for (int i = 0; i < NUM_ALU; i++) begin
         elig_s[i] = (alu_state_q[i] == ST_FREE) && in_alu_ready[i];
         pend_s[i] = (alu_state_q[i] == ST_DONE_PEND);
      end
      for (int i = NUM_ALU - 1; i >= 0; i--) begin
         if (pend_s[i]) begin
            retire_found_s = 1'b1;
            retire_idx_s   = ALU_ID_WIDTH'(i);
         end else begin
            retire_found_s = retire_found_s;
         end
      end
      grant_s     = pick_rr(elig_s, rr_ptr_q);
      grant_idx_s = grant_s[ALU_ID_WIDTH-1:0];
      accept_s    = in_issue_valid && grant_s[ALU_ID_WIDTH];
   end

   // Ready is gated by reset so every output reads 0 while reset is held.
   assign out_issue_ready = rst && (|elig_s);

   // Next-state: retire, completion latch, watchdog, dispatch, counters.
   // Retire and dispatch can never target the same ALU (DONE_PEND vs FREE),
   // and a done pulse only acts on a BUSY ALU, so the updates never collide.
   always_comb begin
      alu_state_d   = alu_state_q;
      wfid_d        = wfid_q;
      rr_ptr_d      = rr_ptr_q;
      alu_select_d  = '0;
      alu_opcode_d  = alu_opcode_q;
      done_valid_d  = 1'b0;
      done_wfid_d   = '0;
      done_alu_id_d = '0;
      done_to_d     = 1'b0;
      proto_err_d   = proto_err_q;
      busy_count_d  = '0;
`ifdef ALU_WATCHDOG_EN
      wdog_cnt_d    = wdog_cnt_q;
      wdog_to_d     = wdog_to_q;
`endif

      if (retire_found_s) begin
         alu_state_d[retire_idx_s] = ST_FREE;
         done_valid_d              = 1'b1;
         done_wfid_d               = wfid_q[retire_idx_s];
         done_alu_id_d             = retire_idx_s;
`ifdef ALU_WATCHDOG_EN
         done_to_d                 = wdog_to_q[retire_idx_s];
         wdog_to_d[retire_idx_s]   = 1'b0;
         if (wdog_to_q[retire_idx_s]) begin
            proto_err_d = 1'b1;
         end else begin
            proto_err_d = proto_err_d;
         end
`endif
      end else begin
         done_valid_d = 1'b0;
      end

      for (int i = 0; i < NUM_ALU; i++) begin
         if (in_instr_done[i]) begin
            if (alu_state_q[i] == ST_BUSY) begin
               alu_state_d[i] = ST_DONE_PEND;
            end else begin
               proto_err_d = 1'b1;
            end
         end else begin
`ifdef ALU_WATCHDOG_EN
            // Expiry only when no done arrived: a done in the expiry cycle
            // is a normal completion.
            if (alu_state_q[i] == ST_BUSY) begin
               if (wdog_cnt_q[i] == CNT_W'(WDOG_CYCLES - 1)) begin
                  alu_state_d[i] = ST_DONE_PEND;
                  wdog_to_d[i]   = 1'b1;
               end else begin
                  wdog_cnt_d[i]  = wdog_cnt_q[i] + CNT_W'(1);
               end
            end else begin
               wdog_cnt_d[i] = wdog_cnt_q[i];
            end
`else
            alu_state_d[i] = alu_state_d[i];
`endif
         end
      end

      if (accept_s) begin
         alu_state_d[grant_idx_s] = ST_BUSY;
         wfid_d[grant_idx_s]      = in_issue_wfid;
         alu_select_d             = NUM_ALU'(1) << grant_idx_s;
         alu_opcode_d             = in_issue_opcode;
         if (grant_idx_s == ALU_ID_WIDTH'(NUM_ALU - 1)) begin
            rr_ptr_d = '0;
         end else begin
            rr_ptr_d = grant_idx_s + ALU_ID_WIDTH'(1);
         end
`ifdef ALU_WATCHDOG_EN
         wdog_cnt_d[grant_idx_s] = '0;
         wdog_to_d[grant_idx_s]  = 1'b0;
`endif
      end else begin
         rr_ptr_d = rr_ptr_q;
      end

      for (int i = 0; i < NUM_ALU; i++) begin
         if (alu_state_d[i] != ST_FREE) begin
            busy_count_d = busy_count_d + (ALU_ID_WIDTH + 1)'(1);
         end else begin
            busy_count_d = busy_count_d;
         end
      end
   end

   // State and output registers, cleared asynchronously by reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_ALU; i++) begin
            alu_state_q[i] <= ST_FREE;
            wfid_q[i]      <= '0;
         end
         rr_ptr_q      <= '0;
         alu_select_q  <= '0;
         alu_opcode_q  <= '0;
         done_valid_q  <= 1'b0;
         done_wfid_q   <= '0;
         done_alu_id_q <= '0;
         done_to_q     <= 1'b0;
         busy_count_q  <= '0;
         proto_err_q   <= 1'b0;
      end else begin
         alu_state_q   <= alu_state_d;
         wfid_q        <= wfid_d;
         rr_ptr_q      <= rr_ptr_d;
         alu_select_q  <= alu_select_d;
         alu_opcode_q  <= alu_opcode_d;
         done_valid_q  <= done_valid_d;
         done_wfid_q   <= done_wfid_d;
         done_alu_id_q <= done_alu_id_d;
         done_to_q     <= done_to_d;
         busy_count_q  <= busy_count_d;
         proto_err_q   <= proto_err_d;
      end
   end

`ifdef ALU_WATCHDOG_EN
   // Watchdog counters and per-ALU timeout flags.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_ALU; i++) begin
            wdog_cnt_q[i] <= '0;
         end
         wdog_to_q <= '0;
      end else begin
         wdog_cnt_q <= wdog_cnt_d;
         wdog_to_q  <= wdog_to_d;
      end
   end
`endif

   assign out_alu_select   = alu_select_q;
   assign out_alu_opcode   = alu_opcode_q;
   assign out_done_valid   = done_valid_q;
   assign out_done_wfid    = done_wfid_q;
   assign out_done_alu_id  = done_alu_id_q;
   assign out_busy_count   = busy_count_q;
   assign out_protocol_err = proto_err_q;
`ifdef ALU_WATCHDOG_EN
   assign out_done_timeout = done_to_q;
`else
   assign out_done_timeout = 1'b0 & done_to_q;
`endif

endmodule

// File: tb/tb_alu_issue_scheduler.sv
// Self-checking bench for alu_issue_scheduler: directed scenarios with
// literal expectations, then randomized traffic compared every cycle against
// a behavioural model of the scheduler kept in plain arrays.
module tb_alu_issue_scheduler;
   localparam int N    = 4;
   localparam int WDOG = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_issue_valid;
   logic [5:0]  in_issue_wfid;
   logic [31:0] in_issue_opcode;
   logic        out_issue_ready;
   logic [3:0]  out_alu_select;
   logic [31:0] out_alu_opcode;
   logic [3:0]  in_alu_ready;
   logic [3:0]  in_instr_done;
   logic        out_done_valid;
   logic [5:0]  out_done_wfid;
   logic [1:0]  out_done_alu_id;
   logic        out_done_timeout;
   logic [2:0]  out_busy_count;
   logic        out_protocol_err;

   alu_issue_scheduler #(
      .NUM_ALU(4), .ALU_ID_WIDTH(2), .WFID_WIDTH(6), .WDOG_CYCLES(WDOG)
   ) dut (
      .clk(clk), .rst(rst),
      .in_issue_valid(in_issue_valid), .in_issue_wfid(in_issue_wfid),
      .in_issue_opcode(in_issue_opcode), .out_issue_ready(out_issue_ready),
      .out_alu_select(out_alu_select), .out_alu_opcode(out_alu_opcode),
      .in_alu_ready(in_alu_ready), .in_instr_done(in_instr_done),
      .out_done_valid(out_done_valid), .out_done_wfid(out_done_wfid),
      .out_done_alu_id(out_done_alu_id), .out_done_timeout(out_done_timeout),
      .out_busy_count(out_busy_count), .out_protocol_err(out_protocol_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Model: 0 = free, 1 = executing, 2 = finished awaiting retire
   int          m_st   [N];
   logic [5:0]  m_wfid [N];
   int          m_cnt  [N];
   bit          m_to   [N];
   int          m_rr;
   logic [31:0] m_op;
   bit          m_err;
   logic [3:0]  e_sel;
   bit          e_dv;
   int          e_id;
   logic [5:0]  e_wfid;
   bit          e_to;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_st[i] = 0; m_wfid[i] = 6'd0; m_cnt[i] = 0; m_to[i] = 1'b0;
      end
      m_rr = 0; m_op = 32'd0; m_err = 1'b0;
      e_sel = 4'd0; e_dv = 1'b0; e_id = 0; e_wfid = 6'd0; e_to = 1'b0;
   endtask

   function automatic bit model_ready();
      bit r = 1'b0;
      for (int i = 0; i < N; i++) if (m_st[i] == 0 && in_alu_ready[i]) r = 1'b1;
      return r && rst;
   endfunction

   function automatic int model_busy();
      int c = 0;
      for (int i = 0; i < N; i++) if (m_st[i] != 0) c++;
      return c;
   endfunction

   // Advance the model across one clock edge using the inputs now applied.
   task automatic model_step();
      int st_old [N];
      bit can_take;
      int g;
      int r;
      st_old   = m_st;
      can_take = model_ready();
      e_sel = 4'd0; e_dv = 1'b0; e_to = 1'b0;
      r = -1;
      for (int i = 0; i < N; i++) if (r < 0 && st_old[i] == 2) r = i;
      if (r >= 0) begin
         e_dv = 1'b1; e_id = r; e_wfid = m_wfid[r]; e_to = m_to[r];
         if (m_to[r]) m_err = 1'b1;
         m_st[r] = 0; m_to[r] = 1'b0;
      end
      for (int i = 0; i < N; i++) begin
         if (in_instr_done[i]) begin
            if (st_old[i] == 1) m_st[i] = 2;
            else m_err = 1'b1;
         end
`ifdef ALU_WATCHDOG_EN
         else if (st_old[i] == 1) begin
            if (m_cnt[i] == WDOG - 1) begin m_st[i] = 2; m_to[i] = 1'b1; end
            else m_cnt[i]++;
         end
`endif
      end
      if (in_issue_valid && can_take) begin
         g = -1;
         for (int k = 0; k < N; k++) begin
            int j;
            j = (m_rr + k) % N;
            if (g < 0 && st_old[j] == 0 && in_alu_ready[j]) g = j;
         end
         m_st[g] = 1; m_wfid[g] = in_issue_wfid; m_cnt[g] = 0; m_to[g] = 1'b0;
         m_rr = (g + 1) % N;
         e_sel = 4'b0001 << g;
         m_op = in_issue_opcode;
      end
   endtask

   // One cycle: drive at negedge, check ready, edge, check registered outputs.
   task automatic step(input logic v, input logic [5:0] w, input logic [31:0] op,
                       input logic [3:0] ar, input logic [3:0] dn);
      in_issue_valid = v; in_issue_wfid = w; in_issue_opcode = op;
      in_alu_ready = ar; in_instr_done = dn;
      #1;
      chk("issue_ready", 64'(out_issue_ready), 64'(model_ready()));
      @(posedge clk);
      model_step();
      @(negedge clk);
      chk("alu_select", 64'(out_alu_select), 64'(e_sel));
      chk("alu_opcode", 64'(out_alu_opcode), 64'(m_op));
      chk("done_valid", 64'(out_done_valid), 64'(e_dv));
      if (e_dv) begin
         chk("done_alu_id", 64'(out_done_alu_id), 64'(e_id));
         chk("done_wfid", 64'(out_done_wfid), 64'(e_wfid));
      end
      chk("done_timeout", 64'(out_done_timeout), 64'(e_to));
      chk("busy_count", 64'(out_busy_count), 64'(model_busy()));
      chk("protocol_err", 64'(out_protocol_err), 64'(m_err));
   endtask

   task automatic idle(input logic [3:0] dn);
      step(1'b0, 6'd0, 32'd0, 4'hF, dn);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_ready"}, 64'(out_issue_ready), 64'd0);
      chk({tag, "_select"}, 64'(out_alu_select), 64'd0);
      chk({tag, "_opcode"}, 64'(out_alu_opcode), 64'd0);
      chk({tag, "_dv"}, 64'(out_done_valid), 64'd0);
      chk({tag, "_wfid"}, 64'(out_done_wfid), 64'd0);
      chk({tag, "_id"}, 64'(out_done_alu_id), 64'd0);
      chk({tag, "_to"}, 64'(out_done_timeout), 64'd0);
      chk({tag, "_busy"}, 64'(out_busy_count), 64'd0);
      chk({tag, "_err"}, 64'(out_protocol_err), 64'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      logic [3:0] busy_mask;
      logic [3:0] dn;
      logic [3:0] ar;
      int         n;
      rst = 1'b0;
      in_issue_valid = 1'b0; in_issue_wfid = 6'd0; in_issue_opcode = 32'd0;
      in_alu_ready = 4'hF; in_instr_done = 4'd0;
      model_reset();
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b1;

      // First dispatch and four back-to-back grants
      step(1'b1, 6'd5, 32'h0000_00A3, 4'hF, 4'd0);
      chk("first_select", 64'(out_alu_select), 64'h1);
      chk("first_opcode", 64'(out_alu_opcode), 64'hA3);
      chk("first_busy", 64'(out_busy_count), 64'd1);
      step(1'b1, 6'd7, 32'h11, 4'hF, 4'd0);
      chk("b2b_select1", 64'(out_alu_select), 64'h2);
      step(1'b1, 6'd8, 32'h22, 4'hF, 4'd0);
      chk("b2b_select2", 64'(out_alu_select), 64'h4);
      step(1'b1, 6'd9, 32'h33, 4'hF, 4'd0);
      chk("b2b_select3", 64'(out_alu_select), 64'h8);
      chk("full_ready", 64'(out_issue_ready), 64'd0);
      chk("full_busy", 64'(out_busy_count), 64'd4);

      // Simultaneous completions on ALUs 1 and 3 retire one per cycle
      idle(4'b1010);
      chk("latch_dv", 64'(out_done_valid), 64'd0);
      idle(4'd0);
      chk("ret1_dv", 64'(out_done_valid), 64'd1);
      chk("ret1_id", 64'(out_done_alu_id), 64'd1);
      chk("ret1_wfid", 64'(out_done_wfid), 64'd7);
      idle(4'd0);
      chk("ret3_dv", 64'(out_done_valid), 64'd1);
      chk("ret3_id", 64'(out_done_alu_id), 64'd3);
      chk("ret3_wfid", 64'(out_done_wfid), 64'd9);
      idle(4'b0101);
      idle(4'd0);
      idle(4'd0);
      chk("drained_busy", 64'(out_busy_count), 64'd0);

      // Move pointer to 2, then grant skips not-ready ALU 2 and wraps
      step(1'b1, 6'd10, 32'h44, 4'hF, 4'd0);
      step(1'b1, 6'd11, 32'h55, 4'hF, 4'd0);
      idle(4'b0011);
      idle(4'd0);
      idle(4'd0);
      step(1'b1, 6'd12, 32'h66, 4'b1011, 4'd0);
      chk("skip_select", 64'(out_alu_select), 64'h8);
      step(1'b1, 6'd13, 32'h77, 4'hF, 4'd0);
      chk("wrap_select", 64'(out_alu_select), 64'h1);

      // Spurious done on a free ALU is sticky
      idle(4'b0100);
      chk("spur_dv", 64'(out_done_valid), 64'd0);
      chk("spur_err", 64'(out_protocol_err), 64'd1);
      idle(4'd0);
      idle(4'd0);
      chk("sticky_err", 64'(out_protocol_err), 64'd1);

      // Asynchronous reset while ALUs are busy
      #2;
      rst = 1'b0;
      #1;
      check_all_zero("async_rst");
      model_reset();
      @(negedge clk);
      rst = 1'b1;

`ifdef ALU_WATCHDOG_EN
      step(1'b1, 6'd21, 32'h99, 4'hF, 4'd0);
      chk("wd_select", 64'(out_alu_select), 64'h1);
      n = 0;
      while (!out_done_valid && n < 40) begin
         idle(4'd0);
         n++;
      end
      chk("wd_latency_ok", 64'(n >= 15 && n <= 17), 64'd1);
      chk("wd_timeout", 64'(out_done_timeout), 64'd1);
      chk("wd_err", 64'(out_protocol_err), 64'd1);
      do_reset();
`endif

      // Randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         busy_mask = 4'd0;
         for (int i = 0; i < N; i++) busy_mask[i] = (m_st[i] == 1);
         dn = busy_mask & 4'($urandom) & 4'($urandom);
         if ($urandom_range(0, 99) == 0) dn = dn | 4'($urandom);
         ar = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
         step(($urandom_range(0, 3) != 0), 6'($urandom), $urandom, ar, dn);
         if (c == 1500) do_reset();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
